// File: rtl/top_4x4.sv
// 4x4 weight-stationary systolic array: weights shift in from the top,
// activations flow right, partial sums flow down, outputs deskewed.
module top_4x4 #(
  parameter int depth     = 4,
  parameter int bit_width = 8,
  parameter int acc_width = 32,
  parameter int size      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        control,
  input  logic [bit_width*depth-1:0]  data_arr,
  input  logic [bit_width*size-1:0]   wt_arr,
  output logic [acc_width*size-1:0]   acc_out
);

  localparam int bw = bit_width;
  localparam int aw = acc_width;

  logic [bw-1:0] w [depth][size];

  logic [bw*depth-1:0]          row_in;
  logic [aw*size*depth-1:0]     psum_bus;
  logic [bw*(size-1)*depth-1:0] data_bus;

  // Weight column shift register; frozen outside the load phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++)
        for (int j = 0; j < size; j++)
          w[i][j] <= '0;
    end else if (control) begin
      for (int j = 0; j < size; j++) begin
        w[0][j] <= wt_arr[bw*j +: bw];
        for (int i = 1; i < depth; i++)
          w[i][j] <= w[i-1][j];
      end
    end
  end

  assign row_in[bw-1:0] = data_arr[bw-1:0];

  for (genvar i = 1; i < depth; i++) begin : g_skew
    logic [bw-1:0] sr [i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < i; k++)
          sr[k] <= '0;
      end else if (control) begin
        for (int k = 0; k < i; k++)
          sr[k] <= '0;
      end else begin
        sr[0] <= data_arr[bw*i +: bw];
        for (int k = 1; k < i; k++)
          sr[k] <= sr[k-1];
      end
    end

    assign row_in[bw*i +: bw] = sr[i-1];
  end

  for (genvar i = 0; i < depth; i++) begin : g_row
    for (genvar j = 0; j < size; j++) begin : g_col
      logic [bw-1:0]   a;
      logic [aw-1:0]   pin;
      logic [2*bw-1:0] prod;
      logic [aw-1:0]   p;

      if (j == 0) begin : g_a_edge
        assign a = row_in[bw*i +: bw];
      end else begin : g_a_chain
        assign a = data_bus[bw*(i*(size-1)+j-1) +: bw];
      end

      if (i == 0) begin : g_p_top
        assign pin = '0;
      end else begin : g_p_chain
        assign pin = psum_bus[aw*((i-1)*size+j) +: aw];
      end

      assign prod = {{bw{1'b0}}, a} * {{bw{1'b0}}, w[i][j]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          p <= '0;
        else if (control)
          p <= '0;
        else
          p <= pin + {{(aw-2*bw){1'b0}}, prod};
      end

      assign psum_bus[aw*(i*size+j) +: aw] = p;

      // Last column has no right-hand neighbour to feed.
      if (j < size-1) begin : g_fwd
        logic [bw-1:0] d;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            d <= '0;
          else if (control)
            d <= '0;
          else
            d <= a;
        end

        assign data_bus[bw*(i*(size-1)+j) +: bw] = d;
      end
    end
  end

  for (genvar j = 0; j < size; j++) begin : g_out
    logic [aw-1:0] bot;

    assign bot = psum_bus[aw*((depth-1)*size+j) +: aw];

    if (j < size-1) begin : g_dly
      logic [aw-1:0] dr [size-1-j];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < size-1-j; k++)
            dr[k] <= '0;
        end else if (control) begin
          for (int k = 0; k < size-1-j; k++)
            dr[k] <= '0;
        end else begin
          dr[0] <= bot;
          for (int k = 1; k < size-1-j; k++)
            dr[k] <= dr[k-1];
        end
      end

      assign acc_out[aw*j +: aw] = dr[size-2-j];
    end else begin : g_direct
      assign acc_out[aw*j +: aw] = bot;
    end
  end

endmodule

// File: tb/tb_top_4x4.sv
// Bench for top_4x4: directed and random steps against a
// queue-of-results model of vector x matrix products.
module tb_top_4x4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         control;
  logic [31:0]  data_arr;
  logic [31:0]  wt_arr;
  logic [127:0] acc_out;

  int tests = 0;
  int fails = 0;

  logic [7:0]   wm [4][4];
  logic [127:0] pipe [7];

  top_4x4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .data_arr (data_arr),
    .wt_arr   (wt_arr),
    .acc_out  (acc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] vec_mul(input logic [31:0] d);
    logic [127:0] r;
    int unsigned s;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++)
        s += int'(d[8*i +: 8]) * int'(wm[i][j]);
      r[32*j +: 32] = s;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        wm[i][j] = '0;
    for (int k = 0; k < 7; k++)
      pipe[k] = '0;
  endtask

  task automatic check(input string tag, input logic [127:0] exp);
    tests++;
    assert (acc_out === exp)
    else begin
      fails++;
      $error("FAIL %s: acc_out=%h expected=%h", tag, acc_out, exp);
    end
  endtask

  task automatic step(input string tag, input logic c,
                      input logic [31:0] d, input logic [31:0] w);
    @(negedge clk);
    control  = c;
    data_arr = d;
    wt_arr   = w;
    @(posedge clk);
    if (c) begin
      for (int j = 0; j < 4; j++) begin
        for (int i = 3; i > 0; i--)
          wm[i][j] = wm[i-1][j];
        wm[0][j] = w[8*j +: 8];
      end
      for (int k = 0; k < 7; k++)
        pipe[k] = '0;
    end else begin
      for (int k = 6; k > 0; k--)
        pipe[k] = pipe[k-1];
      pipe[0] = vec_mul(d);
    end
    #1 check(tag, pipe[6]);
  endtask

  initial begin
    rst_n    = 1'b0;
    control  = 1'b0;
    data_arr = '0;
    wt_arr   = '0;
    model_reset();
    #1 check("reset_state", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++)
      step("zero_weights", 1'b0, 32'h01020304, '0);

    step("load_single", 1'b1, 32'h01020304, 32'h01010101);
    for (int n = 0; n < 9; n++)
      step("single_run", 1'b0, 32'h01020304, '0);
    check("single_const", {4{32'h4}});

    step("load_full", 1'b1, '0, 32'h04030201);
    step("load_full", 1'b1, '0, 32'h08070605);
    step("load_full", 1'b1, '0, 32'h0C0B0A09);
    step("load_full", 1'b1, '0, 32'h100F0E0D);
    for (int n = 0; n < 8; n++)
      step("full_run", 1'b0, 32'h01010101, '0);
    check("full_const", {32'h28, 32'h24, 32'h20, 32'h1C});

    for (int n = 0; n < 8; n++)
      step("lat_idle", 1'b0, '0, '0);
    step("lat_pulse", 1'b0, 32'h01010101, '0);
    for (int n = 0; n < 5; n++)
      step("lat_gap", 1'b0, '0, '0);
    step("lat_hit", 1'b0, '0, '0);
    check("lat_const", {32'h28, 32'h24, 32'h20, 32'h1C});

    for (int n = 0; n < 40; n++)
      step("stream", 1'b0, $urandom, '0);

    for (int n = 0; n < 4; n++)
      step("load_max", 1'b1, '0, 32'hFFFFFFFF);
    for (int n = 0; n < 8; n++)
      step("max_run", 1'b0, 32'hFFFFFFFF, '0);
    check("max_const", {4{32'h0003F804}});

    for (int n = 0; n < 4; n++)
      step("load_rnd", 1'b1, '0, $urandom);
    for (int n = 0; n < 10; n++)
      step("rnd_run", 1'b0, $urandom, '0);
    step("reload_clear", 1'b1, $urandom, $urandom);
    check("reload_zero", '0);
    for (int n = 0; n < 3; n++)
      step("reload", 1'b1, $urandom, $urandom);
    for (int n = 0; n < 20; n++)
      step("after_reload", 1'b0, $urandom, '0);

    for (int n = 0; n < 80; n++)
      step("mixed", ($urandom_range(7) == 0), $urandom, $urandom);
    for (int n = 0; n < 4; n++)
      step("mixed_tail", 1'b0, $urandom, '0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", '0);
    @(posedge clk);
    #1 check("held_reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++)
      step("post_reset", 1'b0, 32'h01020304, '0);
    check("post_reset_const", '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
